smi_uart_arbiter: RTL and testbench
===================================

# smi_uart_arbiter

Packet-level arbiter sharing the single UART transmit byte stream (txuartlite input, `!o_busy` as ready) between two byte sources: the SMI receive stream (source A) and the on-board console/status stream (source B). It grants one source at a time, holds the grant until that source's last byte of a packet, then rotates round-robin. Packets from the two sources never interleave on the wire. An idle-timeout releases a grant when the granted source stalls mid-packet.

## Interface
- `IDLE_TIMEOUT`, 4096: cycles a granted source may present no valid byte before its grant is revoked; legal range 2..65535.
- `OPT_LOWPOWER`, 1'b0: when 1, `M_DATA`/`M_LAST` are forced to 0 whenever `M_VALID` is 0.
- `i_clk`  in  1  system clock (200 MHz in the SMI test design).
- `i_reset`  in  1  asynchronous, active-high reset.
- `S_A_VALID`, `S_A_READY`, `S_A_DATA`[7:0], `S_A_LAST`  in/out/in/in  source A byte stream; LAST marks the final byte of a packet.
- `S_B_VALID`, `S_B_READY`, `S_B_DATA`[7:0], `S_B_LAST`  in/out/in/in  source B, same rules.
- `M_VALID`  out  1  byte available to the UART transmitter.
- `M_READY`  in  1  transmitter accepts (`!tx_busy`).
- `M_DATA`  out  8  byte to transmit.
- `M_LAST`  out  1  final byte of the current packet.
- `o_grant`  out  2  one-hot current owner: 01 = A, 10 = B, 00 = none.
- `o_timeouts`  out  8  saturating count of timeout-forced releases.

## Operation
- FSM states: IDLE, OWN_A, OWN_B.
- IDLE: if exactly one `S_x_VALID` is high, that source is granted next cycle. If both are high, the source not served last is granted. The last-served flag resets to B, so A wins the first tie.
- OWN_x: `S_x_READY = !M_VALID || M_READY`. The other source's READY is 0.
- A transfer happens when `S_x_VALID && S_x_READY`. DATA and LAST are registered into the output stage, and `M_VALID` is set.
- Release: on the cycle a byte with `S_x_LAST=1` is accepted, go to IDLE and set last-served = x. The output register still drains that byte normally.
- Timeout: a 16-bit counter clears on every accepted byte and on entry to OWN_x. It increments each OWN_x cycle with `S_x_VALID=0`. When it reaches `IDLE_TIMEOUT-1`:
  - go to IDLE and set last-served = x;
  - increment `o_timeouts`, saturating at 255.
  - No byte is discarded. The next byte from x starts a new arbitration.
- Output stage: one register. `M_VALID` clears when `M_READY` is high and no new byte is loaded that cycle. `M_DATA`/`M_LAST` hold stable while `M_VALID && !M_READY`.
- `o_grant` is decoded from the state and is 00 in IDLE.
- Reset: state IDLE, `M_VALID=0`, `M_DATA=0`, `M_LAST=0`, `o_grant=0`, `o_timeouts=0`, counter 0, last-served = B. Any byte held in the output register is lost. Reset asserted mid-packet truncates that packet.

## Timing
- Arbitration bubble: 1 cycle. A VALID first seen in IDLE at cycle n gives READY at n+1 at the earliest, assuming the output register is empty or draining.
- Data latency: a byte accepted at cycle n appears on `M_VALID`/`M_DATA` at n+1.
- Throughput: 1 byte/cycle within a packet while `M_READY=1`.
- Between packets there is a ≥1 cycle gap (the IDLE cycle), including back-to-back packets from the same source.
- Simultaneous timeout expiry and valid arrival on the same cycle: the timeout wins. The byte is not accepted because READY was decided from the registered state.
- `S_x_READY` depends combinationally on `M_READY`. No other combinational input-to-output paths exist.
- `M_VALID` never drops without an `M_READY` handshake, and `M_DATA` never changes while stalled.

## Test plan
- Single source: A sends 3-byte packet 0x41,0x42,0x0A(LAST) with `M_READY=1`. `M_DATA` shows 41,42,0A on consecutive cycles, 2 cycles after A first goes valid. `o_grant` returns to 00 after the LAST byte.
- Tie after reset: A and B both valid with 2-byte packets. A is served completely first, then B. Then a fresh tie serves A again, because last-served = B.
- Backpressure: `M_READY` toggles 1,0,0,1 during an A packet. `M_DATA` holds while stalled, `S_A_READY=0` while the register is full and stalled, and no bytes are lost or duplicated.
- Non-interleave: B asserts valid during A's 5-byte packet. B's READY stays 0 until A's LAST is accepted. B's first byte follows after one IDLE cycle.
- Timeout (`IDLE_TIMEOUT=8`): A sends 1 byte without LAST, then idles. After 8 cycles the grant goes to 00 and `o_timeouts=1`. A pending B packet then wins. Force 300 timeouts and check `o_timeouts=255`.
- Reset mid-packet: assert `i_reset` asynchronously, between clock edges, while `M_VALID=1` and B is owner. All outputs go to their reset values immediately. After release, arbitration restarts from IDLE.

Source files
------------

// File: rtl/smi_uart_arbiter_if.sv
// Byte-stream bundle between the two packet sources, the arbiter and the UART
// transmitter. The arbiter connects as slave; the sources/sink side as master.
interface smi_uart_arbiter_if;
   logic       S_A_VALID;
   logic       S_A_READY;
   logic [7:0] S_A_DATA;
   logic       S_A_LAST;
   logic       S_B_VALID;
   logic       S_B_READY;
   logic [7:0] S_B_DATA;
   logic       S_B_LAST;
   logic       M_VALID;
   logic       M_READY;
   logic [7:0] M_DATA;
   logic       M_LAST;

   modport slave (
      input  S_A_VALID, S_A_DATA, S_A_LAST,
      input  S_B_VALID, S_B_DATA, S_B_LAST,
      input  M_READY,
      output S_A_READY, S_B_READY,
      output M_VALID, M_DATA, M_LAST
   );

   modport master (
      output S_A_VALID, S_A_DATA, S_A_LAST,
      output S_B_VALID, S_B_DATA, S_B_LAST,
      output M_READY,
      input  S_A_READY, S_B_READY,
      input  M_VALID, M_DATA, M_LAST
   );
endinterface

// File: rtl/smi_uart_arbiter.sv
// Packet-level round-robin arbiter sharing one UART byte stream between the SMI
// receive stream (A) and the console stream (B), with a stall timeout.
module smi_uart_arbiter #(
   parameter int unsigned IDLE_TIMEOUT = 4096,
   parameter bit          OPT_LOWPOWER = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   smi_uart_arbiter_if.slave  bus,
   output logic [1:0]         o_grant,
   output logic [7:0]         o_timeouts
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   localparam logic [15:0] CNT_MAX = 16'(IDLE_TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        last_b;
   logic [15:0] idle_cnt;

   logic        vld_p1;
   logic [7:0]  m_data_p1;
   logic        m_last_p1;

   logic        out_free;
   logic        expire;
   logic        ready_a;
   logic        ready_b;
   logic        take_a;
   logic        take_b;
   logic        load;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        own_valid;

   // Expiry and READY come only from registered state, so a byte arriving on
   // the expiry cycle is never accepted: the timeout wins.
   always_comb begin
      out_free  = !vld_p1 || bus.M_READY;
      expire    = (state != IDLE) && (idle_cnt == CNT_MAX);
      ready_a   = (state == OWN_A) && out_free && !expire;
      ready_b   = (state == OWN_B) && out_free && !expire;
      take_a    = bus.S_A_VALID && ready_a;
      take_b    = bus.S_B_VALID && ready_b;
      load      = take_a || take_b;
      ld_data   = take_b ? bus.S_B_DATA : bus.S_A_DATA;
      ld_last   = take_b ? bus.S_B_LAST : bus.S_A_LAST;
      own_valid = (state == OWN_B) ? bus.S_B_VALID : bus.S_A_VALID;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.S_A_VALID && bus.S_B_VALID) state_nxt = last_b ? OWN_A : OWN_B;
            else if (bus.S_A_VALID)             state_nxt = OWN_A;
            else if (bus.S_B_VALID)             state_nxt = OWN_B;
         end
         OWN_A:   if (expire || (take_a && bus.S_A_LAST)) state_nxt = IDLE;
         OWN_B:   if (expire || (take_b && bus.S_B_LAST)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         idle_cnt   <= '0;
         last_b     <= 1'b1;
         o_timeouts <= '0;
      end else begin
         if (state == IDLE || load) idle_cnt <= '0;
         else if (!own_valid)       idle_cnt <= idle_cnt + 16'd1;
         if (state == OWN_A && state_nxt == IDLE) last_b <= 1'b0;
         if (state == OWN_B && state_nxt == IDLE) last_b <= 1'b1;
         if (expire && o_timeouts != 8'hFF) o_timeouts <= o_timeouts + 8'd1;
      end
   end

   // Stage p1: single output register feeding the transmitter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         vld_p1    <= 1'b0;
         m_data_p1 <= '0;
         m_last_p1 <= 1'b0;
      end else if (load) begin
         vld_p1    <= 1'b1;
         m_data_p1 <= ld_data;
         m_last_p1 <= ld_last;
      end else if (bus.M_READY) begin
         vld_p1 <= 1'b0;
         if (OPT_LOWPOWER) begin
            m_data_p1 <= '0;
            m_last_p1 <= 1'b0;
         end
      end
   end

   assign bus.S_A_READY = ready_a;
   assign bus.S_B_READY = ready_b;
   assign bus.M_VALID   = vld_p1;
   assign bus.M_DATA    = m_data_p1;
   assign bus.M_LAST    = m_last_p1;
   assign o_grant       = {state == OWN_B, state == OWN_A};

endmodule

// File: tb/tb_smi_uart_arbiter.sv
// Scoreboard bench for smi_uart_arbiter: directed packets push expected bytes,
// a monitor pops and compares every byte the transmitter accepts.
module tb_smi_uart_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant;
   logic [7:0] timeouts;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [8:0] exp_q[$];

   smi_uart_arbiter_if bus();

   smi_uart_arbiter #(.IDLE_TIMEOUT(8), .OPT_LOWPOWER(1'b0)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .bus        (bus),
      .o_grant    (grant),
      .o_timeouts (timeouts)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   task automatic expect_pkt(input logic [39:0] bytes, input int n, input bit end_last);
      for (int i = 0; i < n; i++) exp_q.push_back({end_last && (i == n - 1), bytes[8*i +: 8]});
   endtask

   task automatic drive(input bit src_b, input logic v, input logic [7:0] d, input logic l);
      if (src_b) begin
         bus.S_B_VALID = v; bus.S_B_DATA = d; bus.S_B_LAST = l;
      end else begin
         bus.S_A_VALID = v; bus.S_A_DATA = d; bus.S_A_LAST = l;
      end
   endtask

   // Present n bytes (byte 0 in the LSBs), holding each until the handshake.
   task automatic send(input bit src_b, input logic [39:0] bytes, input int n, input bit end_last);
      for (int i = 0; i < n; i++) begin
         int   waited;
         logic rdy;
         waited = 0;
         drive(src_b, 1'b1, bytes[8*i +: 8], end_last && (i == n - 1));
         do begin
            @(negedge clk);
            rdy = src_b ? bus.S_B_READY : bus.S_A_READY;
            waited++;
         end while (!rdy && waited < 100);
         check(src_b ? "src_b_ready" : "src_a_ready", {31'd0, rdy}, 32'd1);
         if (!rdy) break;
         @(posedge clk); #1;
      end
      drive(src_b, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops on every accepted output byte and checks stall stability.
   initial begin
      logic       stall;
      logic [8:0] held;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge clk);
         if (rst) stall = 1'b0;
         else begin
            if (stall) check("stall_hold", {bus.M_VALID, bus.M_LAST, bus.M_DATA}, {22'd0, 1'b1, held});
            if (bus.M_VALID && bus.M_READY) begin
               if (exp_q.size() == 0) check("sb_pending_count", 32'(exp_q.size()), 32'd1);
               else check("sb_byte", {bus.M_LAST, bus.M_DATA}, exp_q.pop_front());
            end
            stall = bus.M_VALID && !bus.M_READY;
            held  = {bus.M_LAST, bus.M_DATA};
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      bus.M_READY = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_m_valid", {31'd0, bus.M_VALID}, 32'd0);
      check("rst_m_data", {24'd0, bus.M_DATA}, 32'd0);
      check("rst_m_last", {31'd0, bus.M_LAST}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_timeouts", {24'd0, timeouts}, 32'd0);
      check("rst_ready_a", {31'd0, bus.S_A_READY}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Single source, 3-byte packet.
      idle(1);
      expect_pkt(40'h0A4241, 3, 1'b1);
      fork
         send(1'b0, 40'h0A4241, 3, 1'b1);
         begin
            @(negedge clk); check("t1_grant_idle", {30'd0, grant}, 32'd0);
            @(negedge clk); check("t1_grant_a", {30'd0, grant}, 32'd1);
            @(negedge clk); check("t1_out0", {23'd0, bus.M_VALID, bus.M_DATA}, 32'h141);
            @(negedge clk); check("t1_out1", {23'd0, bus.M_VALID, bus.M_DATA}, 32'h142);
            @(negedge clk); check("t1_out2", {23'd0, bus.M_VALID, bus.M_DATA}, 32'h10A);
            check("t1_grant_released", {30'd0, grant}, 32'd0);
         end
      join
      idle(3);

      // Tie after reset: A first, then B; a fresh tie serves A again.
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      expect_pkt(40'hA2A1, 2, 1'b1);
      expect_pkt(40'hB2B1, 2, 1'b1);
      fork
         send(1'b0, 40'hA2A1, 2, 1'b1);
         send(1'b1, 40'hB2B1, 2, 1'b1);
      join
      expect_pkt(40'hA4A3, 2, 1'b1);
      expect_pkt(40'hB4B3, 2, 1'b1);
      fork
         send(1'b0, 40'hA4A3, 2, 1'b1);
         send(1'b1, 40'hB4B3, 2, 1'b1);
      join
      idle(3);

      // Backpressure: M_READY 1,0,0,1 while A streams.
      expect_pkt(40'h13121110, 4, 1'b1);
      fork
         send(1'b0, 40'h13121110, 4, 1'b1);
         begin
            int k;
            k = 0;
            do begin @(negedge clk); k++; end while (!bus.M_VALID && k < 20);
            @(posedge clk); #1 bus.M_READY = 1'b0;
            @(negedge clk);
            check("bp_ready_a_stall0", {31'd0, bus.S_A_READY}, 32'd0);
            check("bp_data_stall0", {23'd0, bus.M_VALID, bus.M_DATA}, 32'h111);
            @(posedge clk); #1 bus.M_READY = 1'b0;
            @(negedge clk);
            check("bp_ready_a_stall1", {31'd0, bus.S_A_READY}, 32'd0);
            @(posedge clk); #1 bus.M_READY = 1'b1;
         end
      join
      idle(3);

      // Non-interleave: B waits through A's 5-byte packet plus one IDLE cycle.
      expect_pkt(40'h3534333231, 5, 1'b1);
      expect_pkt(40'hC2C1, 2, 1'b1);
      fork
         send(1'b0, 40'h3534333231, 5, 1'b1);
         begin repeat (2) @(posedge clk); #1; send(1'b1, 40'hC2C1, 2, 1'b1); end
         begin
            for (int k = 0; k < 7; k++) begin
               @(negedge clk);
               check("ni_b_blocked", {31'd0, bus.S_B_READY}, 32'd0);
            end
            check("ni_idle_gap", {30'd0, grant}, 32'd0);
            @(negedge clk);
            check("ni_b_ready", {31'd0, bus.S_B_READY}, 32'd1);
            check("ni_grant_b", {30'd0, grant}, 32'd2);
         end
      join
      idle(3);

      // Timeout: A stalls mid-packet, pending B takes over.
      expect_pkt(40'h55, 1, 1'b0);
      expect_pkt(40'h66, 1, 1'b1);
      fork
         send(1'b0, 40'h55, 1, 1'b0);
         begin repeat (3) @(posedge clk); #1; send(1'b1, 40'h66, 1, 1'b1); end
         begin
            for (int k = 0; k < 12; k++) begin
               @(negedge clk);
               if (k == 9) begin
                  check("to_grant_before", {30'd0, grant}, 32'd1);
                  check("to_count_before", {24'd0, timeouts}, 32'd0);
               end
               if (k == 10) begin
                  check("to_grant_released", {30'd0, grant}, 32'd0);
                  check("to_count_after", {24'd0, timeouts}, 32'd1);
               end
               if (k == 11) check("to_grant_b", {30'd0, grant}, 32'd2);
            end
         end
      join
      idle(3);

      // Timeout counter saturation.
      for (int i = 0; i < 300; i++) begin
         int w;
         expect_pkt(40'(i & 255), 1, 1'b0);
         send(1'b0, 40'(i & 255), 1, 1'b0);
         w = 0;
         while (grant != 2'b00 && w < 40) begin @(negedge clk); w++; end
         if (i == 198) check("sat_count_mid", {24'd0, timeouts}, 32'd200);
         @(posedge clk); #1;
      end
      check("sat_count_final", {24'd0, timeouts}, 32'd255);
      idle(2);

      // Asynchronous reset while B owns and the output register is full.
      bus.M_READY = 1'b0;
      drive(1'b1, 1'b1, 8'h77, 1'b0);
      @(negedge clk);
      @(negedge clk); check("rm_grant_b", {30'd0, grant}, 32'd2);
      @(negedge clk); check("rm_m_valid_full", {31'd0, bus.M_VALID}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rm_m_valid", {31'd0, bus.M_VALID}, 32'd0);
      check("rm_m_data", {24'd0, bus.M_DATA}, 32'd0);
      check("rm_grant", {30'd0, grant}, 32'd0);
      check("rm_timeouts", {24'd0, timeouts}, 32'd0);
      check("rm_ready_b", {31'd0, bus.S_B_READY}, 32'd0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      bus.M_READY = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      expect_pkt(40'h21, 1, 1'b1);
      fork
         send(1'b0, 40'h21, 1, 1'b1);
         begin
            @(negedge clk); check("rm_restart_idle", {30'd0, grant}, 32'd0);
            @(negedge clk); check("rm_restart_grant_a", {30'd0, grant}, 32'd1);
         end
      join
      idle(5);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
